// File: rtl/fetch_if.sv
// Fetch sequencer bus: ROM read port, decode handshake and status flags.
interface fetch_if #(
    parameter int ADDR_W = 32
);
    logic              start;
    logic              stall;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              mem_en_read;
    logic [ADDR_W-1:0] mem_pc;
    logic [31:0]       mem_inst;
    logic [31:0]       inst_out;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_valid;
    logic              busy;
    logic              halted;
    logic              fault;

    modport master (
        input  start, stall, redirect, redirect_pc, mem_inst,
        output mem_en_read, mem_pc, inst_out, inst_pc,
        output inst_valid, busy, halted, fault
    );

    modport slave (
        output start, stall, redirect, redirect_pc, mem_inst,
        input  mem_en_read, mem_pc, inst_out, inst_pc,
        input  inst_valid, busy, halted, fault
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives ROM reads, squashes on
// redirect and stops on the HALT word or a PC outside the ROM.
module fetch_ctrl #(
    parameter int                ADDR_W    = 32,
    parameter int                MEM_DEPTH = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [31:0]       HALT_WORD = 32'h0000_0000
) (
    input logic      clk,
    input logic      rst,
    fetch_if.master  f
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HALTED,
        FAULT
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(MEM_DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] ipc_q, ipc_d;
    logic              pend_q, pend_d;
    logic              in_rom;
    logic              halt_hit;
    logic              issue;

    assign in_rom   = pc_q <= LAST_PC;
    assign halt_hit = pend_q & (f.mem_inst == HALT_WORD)
                    & ~f.stall & ~f.redirect;
    assign issue    = (state_q == FETCH) & ~f.stall & ~f.redirect
                    & ~halt_hit & in_rom;

    assign f.mem_en_read = issue;
    assign f.mem_pc      = pc_q;
    assign f.inst_out    = f.mem_inst;
    assign f.inst_pc     = ipc_q;
    assign f.inst_valid  = pend_q;
    assign f.busy        = state_q == FETCH;
    assign f.halted      = state_q == HALTED;
    assign f.fault       = state_q == FAULT;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            pend_q  <= 1'b0;
            ipc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            ipc_q   <= ipc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        ipc_d   = ipc_q;
        unique case (state_q)
            FETCH: begin
                // Redirect beats stall and HALT; the in-flight word dies.
                if (f.redirect) begin
                    pc_d   = f.redirect_pc;
                    pend_d = 1'b0;
                end else if (f.stall) begin
                    pend_d = pend_q;
                end else if (halt_hit) begin
                    state_d = HALTED;
                    pend_d  = 1'b0;
                end else if (!in_rom) begin
                    state_d = FAULT;
                    pend_d  = 1'b0;
                end else begin
                    pend_d = 1'b1;
                    ipc_d  = pc_q;
                    pc_d   = pc_q + ADDR_W'(1);
                end
            end
            default: begin
                if (f.start) begin
                    state_d = FETCH;
                    pc_d    = RESET_PC;
                    pend_d  = 1'b0;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized bench for fetch_ctrl: program-order scoreboard fed by the
// stimulus, drained by a monitor on every consumed word.
module tb_fetch_ctrl;

    localparam int DEPTH = 32;

    typedef struct {
        int          pc;
        logic [31:0] w;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fetch_if #(.ADDR_W(32)) f ();

    fetch_ctrl #(
        .ADDR_W(32),
        .MEM_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .f(f)
    );

    logic [31:0] rom [DEPTH];

    // Registered-read ROM that holds its output while not enabled.
    always @(posedge clk)
        if (f.mem_en_read) f.mem_inst <= rom[f.mem_pc[4:0]];

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    bit   running = 0;
    bit   term_halt = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t",
                     name, act, req, $time);
        end
    endtask

    // Straight-line program from t until a HALT word or the ROM end.
    function automatic void load_seq(input int t);
        exp_t e;
        exp_q.delete();
        term_halt = 0;
        for (int a = t; a < DEPTH; a++) begin
            e.pc = a;
            e.w  = rom[a];
            exp_q.push_back(e);
            if (rom[a] == 32'h0) begin
                term_halt = 1;
                break;
            end
        end
    endfunction

    initial begin
        rst = 1'b1;
        f.start = 1'b0;
        f.stall = 1'b0;
        f.redirect = 1'b0;
        f.redirect_pc = '0;
        for (int ph = 0; ph < 8; ph++) begin
            @(negedge clk);
            rst = 1'b1;
            f.start = 1'b0;
            f.stall = 1'b0;
            f.redirect = 1'b0;
            for (int a = 0; a < DEPTH; a++) begin
                if (ph == 0)
                    rom[a] = 32'h100 + 32'(a);
                else if ((ph % 2) == 1 && $urandom_range(0, 7) == 0)
                    rom[a] = 32'h0;
                else
                    rom[a] = $urandom | 32'h1;
            end
            if (ph == 0) rom[22] = 32'h0;
            for (int c = 0; c < 400; c++) begin
                @(negedge clk);
                if (c == 0) begin
                    rst = 1'b0;
                    f.stall = 1'b0;
                    f.redirect = 1'b0;
                    f.start = 1'b1;
                    load_seq(0);
                end else begin
                    rst = ($urandom_range(0, 299) == 0);
                    f.stall = ($urandom_range(0, 3) == 0);
                    f.redirect = ($urandom_range(0, 11) == 0);
                    f.redirect_pc = 32'($urandom_range(0, 35));
                    if (rst)
                        f.start = 1'b0;
                    else if (running)
                        f.start = ($urandom_range(0, 19) == 0);
                    else
                        f.start = ($urandom_range(0, 4) == 0);
                    if (!rst) begin
                        if (running && f.redirect)
                            load_seq(int'(f.redirect_pc));
                        else if (!running && f.start)
                            load_seq(0);
                    end
                end
            end
        end
        @(negedge clk);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    bit   exp_rst = 0, exp_halt = 0, exp_fault = 0;
    bit   p1_launch = 0, p1_quiet = 0, p1_hold = 0, p1_valid = 0;
    bit   p2_launch = 0;
    int   p1_tgt = 0, p2_tgt = 0;

    initial begin
        exp_t e;
        bit   launch, quiet, hold;
        int   tgt;
        forever begin
            @(negedge clk);
            #1;
            if (exp_rst) begin
                chk("rst_en_read", 32'(f.mem_en_read), 0);
                chk("rst_mem_pc", f.mem_pc, 0);
                chk("rst_valid", 32'(f.inst_valid), 0);
                chk("rst_inst_pc", f.inst_pc, 0);
                chk("rst_halted", 32'(f.halted), 0);
                chk("rst_fault", 32'(f.fault), 0);
            end
            if (exp_halt) chk("halted", 32'(f.halted), 1);
            if (exp_fault) chk("fault", 32'(f.fault), 1);
            chk("busy", 32'(f.busy), 32'(running));
            if (!running || f.stall || f.redirect)
                chk("no_read", 32'(f.mem_en_read), 0);
            if (p1_launch) chk("squash_valid", 32'(f.inst_valid), 0);
            if (p2_launch && p1_quiet && p2_tgt < DEPTH) begin
                chk("lat_valid", 32'(f.inst_valid), 1);
                chk("lat_pc", f.inst_pc, 32'(p2_tgt));
            end
            if (p1_hold && p1_valid)
                chk("stall_hold", 32'(f.inst_valid), 1);

            launch = 0;
            hold = 0;
            tgt = 0;
            quiet = !rst && !f.stall && !f.redirect;
            exp_halt = 0;
            exp_fault = 0;
            exp_rst = rst;
            if (rst) begin
                exp_q.delete();
                running = 0;
            end else if (!running) begin
                if (f.start) begin
                    running = 1;
                    launch = 1;
                end
            end else begin
                if (f.redirect) begin
                    launch = 1;
                    tgt = int'(f.redirect_pc);
                end
                hold = f.stall && !f.redirect;
                if (f.inst_valid && !f.redirect) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_word", 32'(f.inst_valid), 0);
                    end else begin
                        e = exp_q[0];
                        chk("word_pc", f.inst_pc, 32'(e.pc));
                        chk("word_val", f.inst_out, e.w);
                        if (!f.stall) begin
                            void'(exp_q.pop_front());
                            if (e.w == 32'h0) begin
                                running = 0;
                                exp_halt = 1;
                            end
                        end
                    end
                end
                if (running && quiet && exp_q.size() == 0
                    && !term_halt) begin
                    running = 0;
                    exp_fault = 1;
                end
            end
            p2_launch = p1_launch;
            p2_tgt = p1_tgt;
            p1_launch = launch;
            p1_tgt = tgt;
            p1_quiet = quiet;
            p1_hold = hold;
            p1_valid = f.inst_valid;
        end
    end

endmodule
